// File: rtl/alu_pkg.sv
// Shared types for the registered, handshaked ALU: op codes, FSM states and the flag set.
package alu_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } alu_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_t;

    typedef struct packed {
        logic carry;
        logic zero;
        logic negative;
        logic overflow;
    } alu_flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle between the controller (master) and the ALU (slave).
interface alu_seq_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) ();

    logic             in_valid;
    logic             in_ready;
    alu_op_t          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             negative;
    logic             overflow;
    logic             busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, carry, zero, negative, overflow, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, carry, zero, negative, overflow, busy
    );

endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: captures operands on start, consumes one multiplier bit per step.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] partial;

    // The final partial product is exposed combinationally so the caller can
    // register it on the same edge that ends the iteration.
    assign partial = acc + (mplier[0] ? mcand : '0);
    assign done    = step && (cnt == LAST);
    assign product = partial;

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            acc    <= partial;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= done ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle add/sub/logic/shift, WIDTH-cycle unsigned multiply, full flag set.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);

    localparam int MSB = WIDTH - 1;

    alu_state_t         state;
    logic [WIDTH-1:0]   res_q;
    alu_flags_t         flags_q;
    logic               valid_q;

    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    alu_flags_t         mul_flags;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   sc_res;
    alu_flags_t         sc_flags;

    assign bus.in_ready  = (state == ST_IDLE) && (!valid_q || bus.out_ready);
    assign bus.busy      = (state == ST_MUL);
    assign bus.out_valid = valid_q;
    assign bus.result    = res_q;
    assign bus.carry     = flags_q.carry;
    assign bus.zero      = flags_q.zero;
    assign bus.negative  = flags_q.negative;
    assign bus.overflow  = flags_q.overflow;

    assign accept    = bus.in_valid && bus.in_ready;
    assign mul_start = accept && (bus.op == OP_MUL);

    // NOTE: every always_comb output gets a default first so no path can
    // infer a latch.
    always_comb begin
        sum      = {1'b0, bus.a} + {1'b0, bus.b};
        diff     = {1'b0, bus.a} - {1'b0, bus.b};
        sc_res   = '0;
        sc_flags = '0;
        case (bus.op)
            OP_ADD: begin
                sc_res            = sum[MSB:0];
                sc_flags.carry    = sum[WIDTH];
                sc_flags.overflow = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB] != bus.a[MSB]);
            end
            OP_SUB: begin
                sc_res            = diff[MSB:0];
                sc_flags.carry    = diff[WIDTH];
                sc_flags.overflow = (bus.a[MSB] != bus.b[MSB]) && (diff[MSB] != bus.a[MSB]);
            end
            OP_AND: sc_res = bus.a & bus.b;
            OP_OR:  sc_res = bus.a | bus.b;
            OP_XOR: sc_res = bus.a ^ bus.b;
            OP_SHL: begin
                sc_res         = {bus.a[MSB-1:0], 1'b0};
                sc_flags.carry = bus.a[MSB];
            end
            OP_SHR: begin
                sc_res         = {1'b0, bus.a[MSB:1]};
                sc_flags.carry = bus.a[0];
            end
            // Only reached without a multiplier: the result is defined as zero.
            OP_MUL: sc_res = '0;
            default: sc_res = '0;
        endcase
        sc_flags.zero     = (sc_res == '0);
        sc_flags.negative = sc_res[MSB];
    end

    always_comb begin
        mul_flags          = '0;
        mul_flags.carry    = |mul_product[2*WIDTH-1:WIDTH];
        mul_flags.zero     = (mul_product[MSB:0] == '0);
        mul_flags.negative = mul_product[MSB];
    end

    generate
        if (MUL_EN) begin : g_mul
            alu_mul_seq #(
                .WIDTH (WIDTH)
            ) u_mul (
                .clk     (clk),
                .rst_n   (rst_n),
                .start   (mul_start),
                .step    (state == ST_MUL),
                .a       (bus.a),
                .b       (bus.b),
                .done    (mul_done),
                .product (mul_product)
            );
        end else begin : g_no_mul
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    // The output register loads only on completion; a new load on the same
    // edge as a consume overrides the clear, keeping out_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            res_q   <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            if (bus.out_ready) begin
                valid_q <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (mul_start && MUL_EN) begin
                            state <= ST_MUL;
                        end else begin
                            res_q   <= sc_res;
                            flags_q <= sc_flags;
                            valid_q <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        state   <= ST_IDLE;
                        res_q   <= mul_product[MSB:0];
                        flags_q <= mul_flags;
                        valid_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8: directed vectors, decoupled monitor, summary line.
module tb_alu_seq;
    import alu_pkg::*;

    typedef struct {
        string      name;
        logic [7:0] res;
        logic [3:0] flags;
        int         exp_edge;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];

    alu_seq_if #(.WIDTH(8)) bus ();

    alu_seq #(
        .WIDTH  (8),
        .MUL_EN (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] act_flags();
        return {bus.carry, bus.zero, bus.negative, bus.overflow};
    endfunction

    // Drive an operation and hold it until accepted; push the expectation at accept.
    task automatic issue(input string name, input alu_op_t op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] er, input logic [3:0] ef,
                         input int lat, input bit expect_out);
        exp_t e;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            #1;
            if (bus.in_ready) begin
                if (expect_out) begin
                    e.name     = name;
                    e.res      = er;
                    e.flags    = ef;
                    e.exp_edge = cyc + lat;
                    sb.push_back(e);
                end
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                bus.op       = OP_ADD;
                bus.a        = 8'hA5;
                bus.b        = 8'h5A;
                return;
            end
            @(posedge clk);
        end
        check({name, "_accept_timeout"}, 0, 1);
        bus.in_valid = 1'b0;
    endtask

    // Monitor: latency on each new presentation, data and flags on each transfer.
    initial begin
        bit   prev_valid;
        bit   prev_fire;
        bit   fire;
        exp_t e;
        prev_valid = 1'b0;
        prev_fire  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                prev_fire  = 1'b0;
            end else begin
                if (bus.out_valid && (!prev_valid || prev_fire)) begin
                    if (sb.size() == 0) check("unexpected_out_valid", 32'd1, 32'd0);
                    else check({sb[0].name, "_latency"}, cyc, sb[0].exp_edge);
                end
                fire = bus.out_valid && bus.out_ready;
                if (fire && sb.size() > 0) begin
                    e = sb.pop_front();
                    check({e.name, "_result"}, bus.result, e.res);
                    check({e.name, "_flags"}, act_flags(), e.flags);
                end
                prev_valid = bus.out_valid;
                prev_fire  = fire;
            end
        end
    end

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.op        = OP_ADD;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_result", bus.result, 8'h00);
        check("reset_flags", act_flags(), 4'b0000);
        check("reset_out_valid", bus.out_valid, 1'b0);
        check("reset_busy", bus.busy, 1'b0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_in_ready", bus.in_ready, 1'b1);

        // Single-cycle ops, back to back; flags are {carry, zero, negative, overflow}.
        issue("add_ff_01", OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b1100, 1, 1'b1);
        issue("add_7f_01", OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b0011, 1, 1'b1);
        issue("sub_05_05", OP_SUB, 8'h05, 8'h05, 8'h00, 4'b0100, 1, 1'b1);
        issue("sub_03_05", OP_SUB, 8'h03, 8'h05, 8'hFE, 4'b1010, 1, 1'b1);
        issue("sub_80_01", OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b0001, 1, 1'b1);
        issue("add_80_80", OP_ADD, 8'h80, 8'h80, 8'h00, 4'b1101, 1, 1'b1);
        issue("and_f0_3c", OP_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1, 1'b1);
        issue("xor_aa_aa", OP_XOR, 8'hAA, 8'hAA, 8'h00, 4'b0100, 1, 1'b1);
        issue("shl_81",    OP_SHL, 8'h81, 8'hFF, 8'h02, 4'b1000, 1, 1'b1);
        issue("shl_40",    OP_SHL, 8'h40, 8'h00, 8'h80, 4'b0010, 1, 1'b1);
        issue("shr_81",    OP_SHR, 8'h81, 8'hFF, 8'h40, 4'b1000, 1, 1'b1);
        issue("shr_01",    OP_SHR, 8'h01, 8'h00, 8'h00, 4'b1100, 1, 1'b1);

        // Multiplies: busy high and in_ready low for all WIDTH cycles.
        issue("mul_0c_0d", OP_MUL, 8'h0C, 8'h0D, 8'h9C, 4'b0010, 9, 1'b1);
        for (int i = 0; i < 8; i++) begin
            #1;
            check("mul_0c_0d_busy", bus.busy, 1'b1);
            check("mul_0c_0d_in_ready", bus.in_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        check("mul_0c_0d_busy_end", bus.busy, 1'b0);
        issue("mul_10_10", OP_MUL, 8'h10, 8'h10, 8'h00, 4'b1100, 9, 1'b1);
        for (int i = 0; i < 8; i++) begin
            #1;
            check("mul_10_10_busy", bus.busy, 1'b1);
            check("mul_10_10_in_ready", bus.in_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        issue("mul_ff_ff", OP_MUL, 8'hFF, 8'hFF, 8'h01, 4'b1000, 9, 1'b1);
        issue("mul_03_05", OP_MUL, 8'h03, 8'h05, 8'h0F, 4'b0000, 9, 1'b1);

        // Backpressure: hold the ADD result, then release and queue an OR on that cycle.
        for (int t = 0; t < 40 && sb.size() > 0; t++) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        issue("add_01_02", OP_ADD, 8'h01, 8'h02, 8'h03, 4'b0000, 1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_out_valid", bus.out_valid, 1'b1);
            check("bp_result_hold", bus.result, 8'h03);
            check("bp_flags_hold", act_flags(), 4'b0000);
            check("bp_in_ready", bus.in_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        issue("or_f0_0f", OP_OR, 8'hF0, 8'h0F, 8'hFF, 4'b0010, 1, 1'b1);

        // Reset in cycle 4 of a multiply: aborted, nothing delivered afterwards.
        @(posedge clk);
        #1;
        issue("mul_abort", OP_MUL, 8'h0C, 8'h0D, 8'h00, 4'b0000, 9, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", bus.out_valid, 1'b0);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_result", bus.result, 8'h00);
        check("abort_flags", act_flags(), 4'b0000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_result_valid", bus.out_valid, 1'b0);
        check("abort_no_result_busy", bus.busy, 1'b0);
        issue("add_10_20", OP_ADD, 8'h10, 8'h20, 8'h30, 4'b0000, 1, 1'b1);

        for (int t = 0; t < 50 && sb.size() > 0; t++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, handshaked successor to the SAP-1 combinational ALU, parametrised in data width. It accepts one operation per valid/ready transfer, computes add/sub/logic/shift in one cycle or an unsigned multiply over WIDTH cycles, and returns a registered result with a full flag set: carry, zero, negative and overflow. It sits between the A/B registers and the bus/flags register of the datapath, so the controller can stall on `busy` or on `out_valid`.

## Interface
- `WIDTH`, 8, data width in bits; legal range ≥ 2.
- `MUL_EN`, 1, enables the sequential multiplier; 0 removes it.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: operands and `op` are valid.
- `in_ready` out 1: block accepts an operation this cycle.
- `op` in 3: operation code (`alu_op_t`).
- `a`, `b` in WIDTH: operands.
- `out_valid` out 1: result and flags are valid; held until consumed.
- `out_ready` in 1: consumer takes the result.
- `result` out WIDTH: registered result.
- `carry`, `zero`, `negative`, `overflow` out 1 each: registered flags for `result`.
- `busy` out 1: multiply in progress.

## Operation
- Op codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SHL=5, SHR=6, MUL=7.
- ADD: `result = a+b` mod 2^WIDTH; `carry` = bit WIDTH of the sum; `overflow` = signed overflow.
- SUB: `result = a-b` mod 2^WIDTH; `carry` = borrow (1 iff a<b unsigned); `overflow` = signed overflow.
- AND, OR, XOR: bitwise; `carry` = 0; `overflow` = 0.
- SHL: `result = a<<1`; `carry = a[WIDTH-1]`. SHR (logical): `result = a>>1`; `carry = a[0]`. `b` is ignored. `overflow` = 0.
- MUL (MUL_EN=1): unsigned shift-add, one bit of `b` per cycle, 2·WIDTH accumulator. `result` = low WIDTH bits; `carry` = 1 iff the high WIDTH bits are nonzero; `overflow` = 0.
- MUL with MUL_EN=0: completes in one cycle with `result` = 0, `zero` = 1, other flags 0.
- For every op: `zero` = (result==0) and `negative` = result[WIDTH-1]. Flags are always fully defined; no op leaves a flag stale.
- State machine (`alu_state_t`): IDLE, MUL.
  - IDLE → MUL on an accepted MUL when MUL_EN=1.
  - MUL → IDLE when the iteration counter reaches WIDTH-1; the result register is loaded on that same edge.
- `in_ready` = (state==IDLE) && (!out_valid || out_ready).
- `busy` = (state==MUL).
- Output register: loaded only on completion. `out_valid` clears on `out_ready` unless a new result loads on the same edge, in which case it stays 1 with the new data.

## Timing
- Reset (async assert, sync release): state IDLE, counter 0, `result` = 0, all flags 0, `out_valid` = 0, `busy` = 0. `in_ready` = 1 from the first cycle after release.
- Single-cycle op accepted at edge N: `out_valid` = 1 with data during cycle N+1 (latency 1). Back-to-back accepts are possible every cycle while `out_ready` = 1.
- MUL accepted at edge N:
  - `busy` = 1 for cycles N+1 … N+WIDTH.
  - Result loads at edge N+WIDTH; `out_valid` = 1 from cycle N+WIDTH+1 (latency WIDTH+1).
  - `in_ready` = 0 throughout.
- Backpressure: with `out_valid` = 1 and `out_ready` = 0, `in_ready` = 0 and `result`/flags hold stable.
- Inputs `a`, `b`, `op` are sampled only at accept; later changes to them never affect an in-flight MUL.
- `rst_n` low mid-MUL aborts the operation immediately. No `out_valid` is produced for the aborted op.

## Structure
- `alu_pkg`: `alu_op_t` (3-bit enum, values above), `alu_state_t`, and a `alu_flags_t` packed struct {carry, zero, negative, overflow}.
- Sub-module `alu_mul_seq`: operand capture, counter of $clog2(WIDTH) bits, accumulator, and `done` pulse. Instantiate it under `generate if (MUL_EN)`.
- Top level holds the combinational single-cycle unit, the FSM and the output register.

## Test plan
All scenarios use WIDTH=8.
- Reset: hold `rst_n` = 0 → `result` = 0x00, all flags 0, `out_valid` = 0. After release, `in_ready` = 1.
- ADD 0xFF+0x01 → `result` 0x00, carry 1, zero 1, overflow 0. ADD 0x7F+0x01 → `result` 0x80, negative 1, overflow 1. Both results appear one cycle after accept.
- SUB 0x05-0x05 → `result` 0x00, zero 1, carry 0. SUB 0x03-0x05 → `result` 0xFE, carry 1, negative 1.
- MUL 0x0C×0x0D → `result` 0x9C, carry 0, with `out_valid` 9 cycles after accept. MUL 0x10×0x10 → `result` 0x00, carry 1, zero 1. `in_ready` = 0 and `busy` = 1 throughout.
- Backpressure: ADD 1+2 with `out_ready` = 0 for 5 cycles → `result` holds 0x03 and `in_ready` = 0. Then OR 0xF0|0x0F queued on the release cycle → 0xFF the next cycle.
- Reset pulse at cycle 4 of a MUL → outputs return to reset values, no `out_valid` is produced, and the next ADD completes normally.
